// File: rtl/dtc_pkg.sv
// Shared types and constants for the DTC link front end.
package dtc_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HDR_W   = 1 + ADDR_W;          // rw + addr
  localparam int unsigned RSP_LEN = 1 + DATA_W + 1 + 1;  // start + data + parity + stop
  localparam int unsigned CNT_W   = $clog2(DATA_W);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_HDR  = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_RX_PAR  = 3'd3,
    ST_RX_STOP = 3'd4,
    ST_ISSUE   = 3'd5,
    ST_WAIT_RD = 3'd6,
    ST_TX      = 3'd7
  } dtc_state_e;

  // Fields of a received command frame.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dtc_cmd_t;

endpackage

// File: rtl/dtc_link_ser.sv
// Response serialiser: start bit, 32 data bits MSB first, even parity, stop bit.
// The start bit appears on o_dout in the cycle after i_load; o_done is high
// while the stop bit is being driven.
module dtc_link_ser
  import dtc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_dout,
  output logic              o_done
);

  localparam int unsigned SER_CNT_W = $clog2(RSP_LEN);

  logic [DATA_W-1:0]    r_shift;
  logic                 r_par;
  logic [SER_CNT_W-1:0] r_cnt;
  logic                 r_active;
  logic                 r_dout;
  logic                 r_done;

  // Shift out one response bit per cycle; line idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_dout   <= STOP_BIT;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_shift  <= i_data;
        r_par    <= ^i_data;
        r_cnt    <= '0;
        r_active <= 1'b1;
        r_dout   <= START_BIT;
      end else if (r_active) begin
        r_cnt <= r_cnt + SER_CNT_W'(1);
        if (r_cnt < SER_CNT_W'(DATA_W)) begin
          r_dout  <= r_shift[DATA_W-1];
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end else if (r_cnt == SER_CNT_W'(DATA_W)) begin
          r_dout <= r_par;
        end else if (r_cnt == SER_CNT_W'(RSP_LEN - 2)) begin
          r_dout <= STOP_BIT;
          r_done <= 1'b1;
        end else begin
          r_dout   <= STOP_BIT;
          r_active <= 1'b0;
        end
      end
    end
  end

  assign o_dout = r_dout;
  assign o_done = r_done;

endmodule

// File: rtl/dtc_link_slave.sv
// Bit-serial DTC link slave: receives command frames on dtc_din, drives the
// dtc_cmd register bus, and returns read data serially on dtc_dout.
// Optional: define DTC_PARITY_CHECK_EN to drop frames with bad parity.
module dtc_link_slave
  import dtc_pkg::*;
#(
  parameter int unsigned       RD_TIMEOUT   = 16,
  parameter int unsigned       ERR_W        = 8,
  parameter logic [DATA_W-1:0] TIMEOUT_WORD = 32'hDEAD_BEEF
) (
  input  logic             dtc_clk,
  input  logic             rst,
  input  logic             dtc_din,
  output logic             dtc_dout,
  output logic [31:0]      address,
  output logic [31:0]      write_data,
  output logic             write,
  output logic             read,
  input  logic [31:0]      read_data,
  input  logic             data_vld,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned TO_W = $clog2(RD_TIMEOUT + 1);

  dtc_state_e        r_state;
  dtc_state_e        w_next;
  logic              r_din_q;
  logic [CNT_W-1:0]  r_bit_cnt;
  dtc_cmd_t          r_cmd;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       r_address;
  logic [31:0]       r_write_data;
  logic              r_write;
  logic              r_read;
  logic              r_busy;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_par_bad;
  logic              w_frame_err;
  logic              w_par_drop;
  logic              w_timeout;
  logic              w_err_inc;
  logic              w_ser_load;
  logic              w_ser_done;
  logic [DATA_W-1:0] w_ser_data;

  // State register.
  always_ff @(posedge dtc_clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic and per-cycle decisions.
  always_comb begin
    w_next      = r_state;
    w_frame_err = 1'b0;
    w_par_drop  = 1'b0;
    w_timeout   = 1'b0;
    w_ser_load  = 1'b0;
    w_ser_data  = read_data;
    case (r_state)
      ST_IDLE: begin
        // A start bit counts only after the line was seen high.
        if ((dtc_din == START_BIT) && (r_din_q == STOP_BIT)) w_next = ST_RX_HDR;
      end
      ST_RX_HDR: begin
        if (r_bit_cnt == CNT_W'(HDR_W - 1)) w_next = r_cmd.rw ? ST_RX_DATA : ST_RX_PAR;
      end
      ST_RX_DATA: begin
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) w_next = ST_RX_PAR;
      end
      ST_RX_PAR: w_next = ST_RX_STOP;
      ST_RX_STOP: begin
        if (dtc_din != STOP_BIT) begin
          w_frame_err = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_par_bad) begin
          w_par_drop = 1'b1;
          w_next     = ST_IDLE;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = r_cmd.rw ? ST_IDLE : ST_WAIT_RD;
      ST_WAIT_RD: begin
        // data_vld wins over a timeout in the same cycle.
        if (data_vld) begin
          w_ser_load = 1'b1;
          w_next     = ST_TX;
        end else if (r_to_cnt == TO_W'(RD_TIMEOUT)) begin
          w_timeout  = 1'b1;
          w_ser_load = 1'b1;
          w_ser_data = TIMEOUT_WORD;
          w_next     = ST_TX;
        end
      end
      ST_TX: begin
        if (w_ser_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_err_inc = w_frame_err | w_par_drop | w_timeout;

  // Receive shifting, bit counter and read-timeout counter.
  always_ff @(posedge dtc_clk or negedge rst) begin
    if (!rst) begin
      r_din_q   <= STOP_BIT;
      r_bit_cnt <= '0;
      r_cmd     <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_din_q   <= dtc_din;
      r_bit_cnt <= (w_next != r_state) ? '0 : r_bit_cnt + CNT_W'(1);
      if (r_state == ST_RX_HDR) begin
        if (r_bit_cnt == '0) r_cmd.rw <= dtc_din;
        else                 r_cmd.addr <= {r_cmd.addr[ADDR_W-2:0], dtc_din};
      end
      if (r_state == ST_RX_DATA) r_cmd.data <= {r_cmd.data[DATA_W-2:0], dtc_din};
      r_to_cnt <= (r_state == ST_WAIT_RD) ? r_to_cnt + TO_W'(1) : '0;
    end
  end

  // Bus strobes, held address/data, busy flag and saturating error count.
  always_ff @(posedge dtc_clk or negedge rst) begin
    if (!rst) begin
      r_address    <= '0;
      r_write_data <= '0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_busy       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      if ((r_state == ST_RX_STOP) && (w_next == ST_ISSUE)) begin
        r_address <= 32'(r_cmd.addr);
        if (r_cmd.rw) r_write_data <= r_cmd.data;
        r_write <= r_cmd.rw;
        r_read  <= ~r_cmd.rw;
      end
      r_busy <= (w_next != ST_IDLE);
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

`ifdef DTC_PARITY_CHECK_EN
  logic r_par_acc;
  logic r_par_err;

  // Running parity over rw/addr/data, compared with the received parity bit.
  always_ff @(posedge dtc_clk or negedge rst) begin
    if (!rst) begin
      r_par_acc <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_par_acc <= 1'b0;
      else if ((r_state == ST_RX_HDR) || (r_state == ST_RX_DATA)) r_par_acc <= r_par_acc ^ dtc_din;
      if (r_state == ST_RX_PAR) r_par_err <= r_par_acc ^ dtc_din;
    end
  end

  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  dtc_link_ser u_ser (
    .i_clk   (dtc_clk),
    .i_rst_n (rst),
    .i_load  (w_ser_load),
    .i_data  (w_ser_data),
    .o_dout  (dtc_dout),
    .o_done  (w_ser_done)
  );

  assign address    = r_address;
  assign write_data = r_write_data;
  assign write      = r_write;
  assign read       = r_read;
  assign busy       = r_busy;
  assign err_cnt    = r_err_cnt;

endmodule
